// File: rtl/mc_controller.sv
// mc_controller: main control FSM for the multicycle RV32I core.
// Advances one micro-step per cycle. Outputs are decoded from the registered state.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready. Defining MC_CTRL_TRAP_EN parks illegal opcodes in TRAP.
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALRLINK = 4'd13,
    S_LUI      = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_e state_q, state_d;
  state_e dec_state;
  logic   dec_done;
  logic   br_taken;

  // Opcode classification: where DECODE goes next and whether it ends the instruction
  always_comb begin
    dec_state = S_FETCH;
    dec_done  = 1'b0;
    case (op)
      OP_LOAD, OP_STORE:    dec_state = S_MEMADR;
      OP_RTYPE:             dec_state = S_EXECR;
      OP_ITYPE:             dec_state = S_EXECI;
      OP_BRANCH:            dec_state = S_BRANCH;
      OP_JAL:               dec_state = S_JAL;
      OP_JALR:              dec_state = S_JALR;
      OP_LUI:               dec_state = S_LUI;
      OP_AUIPC:             dec_state = S_ALUWB;
      OP_FENCE, OP_SYSTEM:  dec_done  = 1'b1;
      default: begin
`ifdef MC_CTRL_TRAP_EN
        dec_state = S_TRAP;
`else
        dec_done  = 1'b1;
`endif
      end
    endcase
  end

  // Branch condition from funct3 and the ALU flags of the rs1-rs2 subtraction
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = ~ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = dec_state;
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRLINK;
      S_JALRLINK: state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
`ifdef MC_CTRL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_RST;
    endcase
  end

  // State register; reset drops straight back to RST even mid-wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Control decode from the current state (a few strobes qualified by inputs)
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        instr_done = dec_done;
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = br_taken;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_JALRLINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
      end
`ifdef MC_CTRL_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction stream against a per-instruction timing model.
// The model derives cycle count, memory windows and strobe counts from the instruction class.
// Memory ready is driven by the model so each wait-state count is known up front.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       instr_done, trap;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations of the most recent instruction, indexed by cycle
  logic [3:0] obs_state [0:63];
  logic [1:0] obs_rs    [0:63];
  logic [1:0] obs_a     [0:63];

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_NOP = 9, K_ILL = 10;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .instr_done(instr_done), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] all_outs();
    return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, alu_op, result_src, instr_done, trap, state};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [6:0] op_of(input int k);
    logic [6:0] ill [0:3];
    ill[0] = 7'b0000000; ill[1] = 7'b1111111; ill[2] = 7'b0100111; ill[3] = 7'b1010011;
    case (k)
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      K_NOP:   return ($urandom % 2) ? 7'b0001111 : 7'b1110011;
      default: return ill[$urandom % 4];
    endcase
  endfunction

  function automatic int cpi(input int k);
    case (k)
      K_NOP, K_ILL:                   return 2;
      K_BR, K_AUIPC:                  return 3;
      K_R, K_I, K_STORE, K_JAL, K_LUI: return 4;
      default:                        return 5; // load, jalr
    endcase
  endfunction

  function automatic bit branch_taken(input logic [2:0] f3, input logic z, input logic l, input logic u);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return u;
      3'd7: return !u;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one instruction starting at cycle 0 of FETCH (called at posedge+1).
  // wf/wm: wait cycles on the fetch and data accesses.
  task automatic run_instr(input int k, input logic [2:0] f3, input logic z, input logic l,
                           input logic u, input int wf, input int wm);
    bit is_mem   = (k == K_LOAD) || (k == K_STORE);
    int wmx      = is_mem ? wm : 0;
    int len      = cpi(k) + wf + wmx;
    int mstart   = wf + 3;
    int n_rw = 0, n_pw = 0, n_mw = 0, n_sub = 0, n_fn = 0;
    int exp_pw   = 1;
    int exp_rw;
    bit in_f, in_m;
    if (k == K_BR) exp_pw += branch_taken(f3, z, l, u);
    if (k == K_JAL || k == K_JALR) exp_pw += 1;
    exp_rw = (k == K_STORE || k == K_BR || k == K_NOP || k == K_ILL) ? 0 : 1;
    op = op_of(k); funct3 = f3; zero = z; lt = l; ltu = u;
    for (int c = 0; c < len; c++) begin
      in_f = (c <= wf);
      in_m = is_mem && (c >= mstart) && (c <= mstart + wmx);
      if (in_f)      mem_ready = (c == wf);
      else if (in_m) mem_ready = (c == mstart + wmx);
      else           mem_ready = $urandom % 2;
      #4;
      check("mem_req", mem_req, in_f || in_m);
      check("adr_src", adr_src, in_m);
      check("ir_write", ir_write, in_f && (c == wf));
      check("instr_done", instr_done, c == len - 1);
      check("trap", trap, 1'b0);
      if (reg_write) check("result_src_wb", result_src, (k == K_LOAD) ? 2'b01 : 2'b00);
      obs_state[c] = state; obs_rs[c] = result_src; obs_a[c] = alu_src_a;
      n_rw  += reg_write;
      n_pw  += pc_write;
      n_mw  += mem_write;
      n_sub += (alu_op == 2'b01);
      n_fn  += (alu_op == 2'b10);
      @(posedge clk); #1;
    end
    check("reg_write_cnt", n_rw, exp_rw);
    check("pc_write_cnt",  n_pw, exp_pw);
    check("mem_write_cnt", n_mw, (k == K_STORE) ? wmx + 1 : 0);
    check("alu_sub_cnt",   n_sub, (k == K_BR) ? 1 : 0);
    check("alu_fn_cnt",    n_fn, (k == K_R || k == K_I) ? 1 : 0);
  endtask

  // Holds reset, checks the quiescent outputs, releases and checks the first FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 20'd0);
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    check("rst_held_outs", all_outs(), 20'd0);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_first_state", state, 4'd1);
    check("rst_first_req", mem_req, 1'b1);
    check("rst_first_adr", adr_src, 1'b0);
  endtask

  initial begin
    int k, nk;
    #1 rst_n = 1'b0;
    do_reset();

    // R-type, no waits
    run_instr(K_R, 3'd0, 0, 0, 0, 0, 0);
    check("r_s0", obs_state[0], 4'd1);
    check("r_s1", obs_state[1], 4'd2);
    check("r_s2", obs_state[2], 4'd7);
    check("r_s3", obs_state[3], 4'd9);

    // Load with two wait cycles on the data read
    run_instr(K_LOAD, 3'd2, 0, 0, 0, 0, 2);
    check("ld_s3", obs_state[3], 4'd4);
    check("ld_s5", obs_state[5], 4'd4);
    check("ld_s6", obs_state[6], 4'd5);
    check("ld_rs6", obs_rs[6], 2'b01);

    // BNE both ways
    run_instr(K_BR, 3'd1, 1'b0, 0, 0, 0, 0);
    check("bne_s2", obs_state[2], 4'd10);
    run_instr(K_BR, 3'd1, 1'b1, 0, 0, 0, 0);
    check("bneq_s2", obs_state[2], 4'd10);

    // JALR
    run_instr(K_JALR, 3'd0, 0, 0, 0, 0, 0);
    check("jalr_s2", obs_state[2], 4'd12);
    check("jalr_rs2", obs_rs[2], 2'b10);
    check("jalr_a2", obs_a[2], 2'b10);
    check("jalr_s3", obs_state[3], 4'd13);
    check("jalr_s4", obs_state[4], 4'd9);

    // Illegal opcode
`ifdef MC_CTRL_TRAP_EN
    op = 7'b1111111; mem_ready = 1'b1;
    @(posedge clk); #1;          // DECODE
    mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = $urandom % 2;
      #4;
      check("trap_state", state, 4'd15);
      check("trap_flag", trap, 1'b1);
      check("trap_req", mem_req, 1'b0);
      @(posedge clk); #1;
    end
    do_reset();
`else
    op = 7'b1111111;
    run_instr(K_ILL, 3'd0, 0, 0, 0, 0, 0);
    check("ill_s1", obs_state[1], 4'd2);
`endif

    // Random instruction stream
`ifdef MC_CTRL_TRAP_EN
    nk = K_NOP;
`else
    nk = K_ILL;
`endif
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, nk);
      run_instr(k, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom % 3 == 0) ? $urandom_range(1, 3) : 0,
                ($urandom % 3 == 0) ? $urandom_range(1, 3) : 0);
    end

    // Asynchronous reset in the middle of a fetch wait
    op = 7'b0000011; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_mid_outs", all_outs(), 20'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("async_refetch", state, 4'd1);
    run_instr(K_LOAD, 3'd0, 0, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
